udp_tx_framer_mux: RTL
======================

// Module: udp_tx_framer_mux
// PURPOSE
//  Packet-atomic N:1 mux plus UDP/IP header prepender for the fifo36 TX path (next generation of the single-channel framer).
//  Round-robin arbitrates NUM_CHAN fifo36 payload streams, prepends HDR_WORDS per-channel header words, emits one fifo36 stream.
//  Sits between DSP/VITA TX framers and the fifo36->fifo19 Ethernet conversion.
// PARAMETERS
//  BASE       0  settings-bus base address
//  NUM_CHAN   4  input channels, 1..8
//  HDR_WORDS  7  36-bit header words per channel, 1..14; NUM_CHAN*HDR_WORDS+1 <= 256-BASE
// PORTS
//  clk          in   1            single clock
//  reset_n      in   1            asynchronous, active-low reset
//  clear        in   1            synchronous flush
//  set_stb      in   1            settings write strobe
//  set_addr     in   8            settings address
//  set_data     in   32           settings data
//  in_data      in   NUM_CHAN*36  channel c in [c*36+35:c*36]; fifo36 format
//  in_src_rdy   in   NUM_CHAN     per-channel source ready
//  in_dst_rdy   out  NUM_CHAN     per-channel destination ready
//  out_data     out  36           merged fifo36 stream
//  out_src_rdy  out  1            output valid
//  out_dst_rdy  in   1            downstream ready
//  debug        out  32           [2:0] grant, [4:3] state, [15:8] drop count, [31:16] see CONFIGURATION
// BEHAVIOUR
//  fifo36 word: [31:0] data, [32] SOF, [33] EOF, [35:34] occ (0 = 4 bytes valid, 1..3 = bytes valid on EOF word).
//  Transfer = src_rdy & dst_rdy in the same cycle.
//  Reset: outputs 0; header regs 0; enable mask 0; state IDLE; last_grant = NUM_CHAN-1.
//  Settings map:
//   BASE + c*HDR_WORDS + i -> header word i of channel c (sets [31:0]; flags generated).
//   BASE + NUM_CHAN*HDR_WORDS -> enable mask [NUM_CHAN-1:0].
//  FSM:
//   IDLE: among channels with enable & in_src_rdy, pick first after last_grant (wrap). Register grant.
//         Go HDR if head word SOF=1, else DRAIN. No in_dst_rdy asserted in IDLE.
//   HDR: out_src_rdy=1; out_data = header word idx; word 0 has SOF=1; all header words EOF=0, occ=0.
//        idx++ per transfer; after idx HDR_WORDS-1 transfers -> PAYLOAD.
//   PAYLOAD: combinational pass-through of granted channel.
//        out_data = in_data with SOF forced 0; out_src_rdy = in_src_rdy[g]; in_dst_rdy[g] = out_dst_rdy.
//        Transfer with EOF -> IDLE, last_grant = g.
//   DRAIN: in_dst_rdy[g]=1, out_src_rdy=0; discard words through EOF; drop count++ (saturates 255) -> IDLE.
//  Non-granted channels: in_dst_rdy=0 always.
//  Packet gap: exactly one IDLE cycle between packets; first header word valid cycle after grant.
//  Single-word payload (SOF&EOF): header, then that word with EOF kept and SOF cleared.
//  Enable cleared mid-packet: current packet completes; channel excluded from next arbitration.
//  Header write during HDR of same channel: each word emitted reflects register value at its transfer cycle.
//  clear: state IDLE, idx 0, last_grant NUM_CHAN-1, drop count 0; header regs and enable kept.
//   Mid-packet clear truncates without EOF; downstream shares clear.
// CONFIGURATION
//  UDP_FRAMER_STATS_EN defined: 16-bit packet counter increments on each output EOF transfer; wraps 0xFFFF->0.
//   Cleared by reset/clear; driven on debug[31:16].
//  Not defined: no counter logic; debug[31:16] = 0.
// STRUCTURE
//  Package udp_framer_pkg: fifo36 bit indices (SOF/EOF/OCC), state encoding, header address offset function.
//  Sub-module rr_arb_pick: combinational rotating-priority picker (req, last_grant -> grant, valid).
// TESTING
//  Ch0 only, HDR_WORDS=7, 4-word payload -> 11 output words; word0 SOF=1, word10 EOF=1 with input occ; then 1 idle cycle.
//  Ch0..3 all pending continuously -> grants 0,1,2,3,0; no interleaving inside a packet.
//  out_dst_rdy random 50% -> output identical to no-backpressure run; no word lost or duplicated.
//  Ch2 head word lacks SOF, 3 words ending EOF -> all 3 consumed, nothing output, debug[15:8]=1.
//  Clear asserted during PAYLOAD -> next cycle IDLE; next grant ch0; header regs retained.
//  With UDP_FRAMER_STATS_EN, 65537 single-word packets -> debug[31:16]=1; without macro -> 0.
//  reset_n asserted mid-packet -> outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/udp_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : udp_framer_pkg                                         |
// | Description : Shared definitions for the UDP TX framer mux: fifo36   |
// |               bit positions, FSM state encoding and header register  |
// |               address helper.                                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package udp_framer_pkg;

  // fifo36 word layout
  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_LSB = 34;
  localparam int OCC_MSB = 35;

  // Grant index width covers up to 8 channels
  localparam int GRANT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Offset of header word idx of channel chan from the settings base
  function automatic int hdr_addr_offset(input int chan, input int idx, input int hdr_words);
    return chan * hdr_words + idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_framer_mux_rr_arb_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_arb_pick                                            |
// | Description : Combinational rotating-priority picker. The first      |
// |               requesting channel after last_grant (wrapping) wins.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_arb_pick
  import udp_framer_pkg::*;
#(
  parameter int NUM_CHAN = 4
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [GRANT_W-1:0]  last_grant,
  output logic [GRANT_W-1:0]  grant,
  output logic                valid
);

  // Scan from farthest to nearest candidate so the nearest requester overwrites
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = NUM_CHAN; k >= 1; k--) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (req[c] && (GRANT_W'((int'(last_grant) + k) % NUM_CHAN) == GRANT_W'(c))) begin
          grant = GRANT_W'(c);
          valid = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/udp_tx_framer_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : udp_tx_framer_mux                                      |
// | Description : Packet-atomic round-robin N:1 fifo36 mux that prepends |
// |               HDR_WORDS programmable header words per channel.       |
// |               Optional macro UDP_FRAMER_STATS_EN adds a 16-bit       |
// |               output packet counter on debug[31:16].                 |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module udp_tx_framer_mux
  import udp_framer_pkg::*;
#(
  parameter int BASE      = 0,
  parameter int NUM_CHAN  = 4,
  parameter int HDR_WORDS = 7
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  input  logic [NUM_CHAN*36-1:0] in_data,
  input  logic [NUM_CHAN-1:0]    in_src_rdy,
  output logic [NUM_CHAN-1:0]    in_dst_rdy,
  output logic [35:0]            out_data,
  output logic                   out_src_rdy,
  input  logic                   out_dst_rdy,
  output logic [31:0]            debug
);

  localparam int NUM_HDR   = NUM_CHAN * HDR_WORDS;
  localparam int CTRL_ADDR = BASE + NUM_HDR;

  state_t               state;
  logic [GRANT_W-1:0]   grant;
  logic [GRANT_W-1:0]   last_grant;
  logic [3:0]           idx;
  logic [7:0]           drop_cnt;
  logic [NUM_CHAN-1:0]  enable;
  logic [31:0]          hdr_reg [NUM_HDR];
  logic [15:0]          stats;

  logic [GRANT_W-1:0]   pick;
  logic                 pick_valid;
  logic                 pick_sof;
  logic [35:0]          cur_data;
  logic                 cur_src;
  logic [31:0]          hdr_word;

  rr_arb_pick #(.NUM_CHAN(NUM_CHAN)) u_pick (
    .req        (enable & in_src_rdy),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  // Select granted channel's head word, the candidate's SOF and the current header word
  always_comb begin
    cur_data = '0;
    cur_src  = 1'b0;
    pick_sof = 1'b0;
    hdr_word = '0;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (grant == GRANT_W'(c)) begin
        cur_data = in_data[c*36 +: 36];
        cur_src  = in_src_rdy[c];
      end
      if (pick == GRANT_W'(c)) begin
        pick_sof = in_data[c*36 + SOF_BIT];
      end
      for (int i = 0; i < HDR_WORDS; i++) begin
        if ((grant == GRANT_W'(c)) && (idx == 4'(i))) begin
          hdr_word = hdr_reg[c*HDR_WORDS + i];
        end
      end
    end
  end

  // Settings bus: header words and enable mask survive clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable <= '0;
      for (int r = 0; r < NUM_HDR; r++) begin
        hdr_reg[r] <= '0;
      end
    end else if (set_stb) begin
      if (set_addr == 8'(CTRL_ADDR)) begin
        enable <= set_data[NUM_CHAN-1:0];
      end
      for (int c = 0; c < NUM_CHAN; c++) begin
        for (int i = 0; i < HDR_WORDS; i++) begin
          if (set_addr == 8'(BASE + hdr_addr_offset(c, i, HDR_WORDS))) begin
            hdr_reg[c*HDR_WORDS + i] <= set_data;
          end
        end
      end
    end
  end

  // Packet FSM: arbitrate, emit header, pass payload or drain a malformed packet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GRANT_W'(NUM_CHAN - 1);
      idx        <= '0;
      drop_cnt   <= '0;
    end else if (clear) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_W'(NUM_CHAN - 1);
      idx        <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (pick_valid) begin
            grant <= pick;
            state <= pick_sof ? ST_HDR : ST_DRAIN;
          end
        end
        ST_HDR: begin
          if (out_dst_rdy) begin
            if (idx == 4'(HDR_WORDS - 1)) begin
              idx   <= '0;
              state <= ST_PAYLOAD;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (cur_src && out_dst_rdy && cur_data[EOF_BIT]) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: begin
          // Drained channel also rotates priority so a faulty source cannot hog the arbiter
          if (cur_src && cur_data[EOF_BIT]) begin
            if (drop_cnt != 8'hFF) begin
              drop_cnt <= drop_cnt + 8'd1;
            end
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Output steering: header words, payload pass-through, or drain handshake
  always_comb begin
    out_data    = '0;
    out_src_rdy = 1'b0;
    in_dst_rdy  = '0;
    case (state)
      ST_HDR: begin
        out_src_rdy = 1'b1;
        out_data    = {2'b00, 1'b0, (idx == 4'd0), hdr_word};
      end
      ST_PAYLOAD: begin
        out_src_rdy       = cur_src;
        out_data          = cur_data;
        out_data[SOF_BIT] = 1'b0;
        for (int c = 0; c < NUM_CHAN; c++) begin
          if (grant == GRANT_W'(c)) in_dst_rdy[c] = out_dst_rdy;
        end
      end
      ST_DRAIN: begin
        for (int c = 0; c < NUM_CHAN; c++) begin
          if (grant == GRANT_W'(c)) in_dst_rdy[c] = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef UDP_FRAMER_STATS_EN
  // Count output packets (EOF transfers), wrapping at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stats <= '0;
    end else if (clear) begin
      stats <= '0;
    end else if (out_src_rdy && out_dst_rdy && out_data[EOF_BIT]) begin
      stats <= stats + 16'd1;
    end
  end
`else
  assign stats = '0;
`endif

  assign debug = {stats, drop_cnt, 3'b000, state, grant};

endmodule
`default_nettype wire
